// File: rtl/jclock_seq.sv
// Four-phase CPU clock generator (clk, clkd, clke, clks) with a programmable
// prescaler, one-hot stepper, and run/halt/single-cycle/single-instruction modes.
module jclock_seq #(
  parameter int DIV    = 2,
  parameter int NSTEPS = 6,
  parameter int SW     = $clog2(NSTEPS)
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic              go,
  input  logic              step_clr,
  output logic              clk,
  output logic              clkd,
  output logic              clke,
  output logic              clks,
  output logic [NSTEPS-1:0] step_out,
  output logic [SW-1:0]     step_idx,
  output logic              wrap,
  output logic              halted
);

  // state   | meaning
  // S_IDLE  | parked at rest phase q=3, prescaler held, halted=1
  // S_RUN   | free-running; re-checks mode at each boundary
  // S_CYC   | one full clk cycle, then back to S_IDLE
  // S_INSTR | runs until the boundary at the last step
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CYC, S_INSTR} state_t;

  localparam int              PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PTC    = PW'(DIV - 1);
  localparam logic [SW-1:0]   LAST   = SW'(NSTEPS - 1);
  localparam logic [1:0]      M_RUN  = 2'd0;
  localparam logic [1:0]      M_CYC  = 2'd2;
  localparam logic [1:0]      M_INST = 2'd3;

  state_t        state;
  logic [PW-1:0] presc;
  logic [1:0]    q;
  logic [1:0]    q_nxt;
  logic          primed;
  logic          tick;
  logic          boundary;
  logic          step_adv;

  assign tick     = (state != S_IDLE) && (presc == PTC);
  assign q_nxt    = tick ? q + 2'd1 : q;
  assign boundary = tick && (q == 2'd2);
  assign step_adv = tick && (q == 2'd3);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      presc    <= '0;
      q        <= 2'd3;
      primed   <= 1'b0;
      step_out <= '0;
      step_idx <= '0;
      wrap     <= 1'b0;
      halted   <= 1'b1;
      clk      <= 1'b0;
      clkd     <= 1'b0;
      clke     <= 1'b0;
      clks     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      q    <= q_nxt;
      // Phase outputs are decoded from the next q so they move with q itself.
      clk  <= (q_nxt == 2'd0) || (q_nxt == 2'd1);
      clkd <= (q_nxt == 2'd1) || (q_nxt == 2'd2);
      clke <= (q_nxt != 2'd3);
      clks <= (q_nxt == 2'd1);

      if ((state == S_IDLE) || tick) presc <= '0;
      else                           presc <= presc + PW'(1);

      case (state)
        S_IDLE: begin
          if (mode == M_RUN) begin
            state  <= S_RUN;
            halted <= 1'b0;
          end else if (go && (mode == M_CYC)) begin
            state  <= S_CYC;
            halted <= 1'b0;
          end else if (go && (mode == M_INST)) begin
            state  <= S_INSTR;
            halted <= 1'b0;
          end
          if (step_clr) begin
            primed   <= 1'b0;
            step_idx <= '0;
            step_out <= '0;
          end
        end
        S_RUN: begin
          if (boundary && (mode != M_RUN)) begin
            state  <= S_IDLE;
            halted <= 1'b1;
          end
        end
        S_CYC: begin
          if (boundary) begin
            state  <= S_IDLE;
            halted <= 1'b1;
          end
        end
        S_INSTR: begin
          if (boundary && (step_idx == LAST)) begin
            state  <= S_IDLE;
            halted <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          halted <= 1'b1;
        end
      endcase

      if (step_adv) begin
        if (!primed) begin
          primed   <= 1'b1;
          step_idx <= '0;
          step_out <= NSTEPS'(1);
        end else if (step_idx == LAST) begin
          step_idx <= '0;
          step_out <= NSTEPS'(1);
          wrap     <= 1'b1;
        end else begin
          step_idx <= step_idx + SW'(1);
          step_out <= step_out << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jclock_seq.sv
// Directed bench for jclock_seq: DIV=1 instance for run/instr/reset, DIV=2 for single-cycle.
module tb_jclock_seq;

  localparam logic [1:0] M_RUN  = 2'd0;
  localparam logic [1:0] M_HALT = 2'd1;
  localparam logic [1:0] M_CYC  = 2'd2;
  localparam logic [1:0] M_INST = 2'd3;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] mode1, mode2;
  logic       go1, go2, clr1, clr2;
  logic       clk1, clkd1, clke1, clks1, wrap1, halted1;
  logic       clk2, clkd2, clke2, clks2, wrap2, halted2;
  logic [5:0] so1, so2;
  logic [2:0] idx1, idx2;

  jclock_seq #(.DIV(1), .NSTEPS(6)) u1 (
    .CLK(CLK), .reset_n(reset_n), .mode(mode1), .go(go1), .step_clr(clr1),
    .clk(clk1), .clkd(clkd1), .clke(clke1), .clks(clks1),
    .step_out(so1), .step_idx(idx1), .wrap(wrap1), .halted(halted1)
  );

  jclock_seq #(.DIV(2), .NSTEPS(6)) u2 (
    .CLK(CLK), .reset_n(reset_n), .mode(mode2), .go(go2), .step_clr(clr2),
    .clk(clk2), .clkd(clkd2), .clke(clke2), .clks(clks2),
    .step_out(so2), .step_idx(idx2), .wrap(wrap2), .halted(halted2)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_por(input string tag);
    chk({tag, ".halted"}, int'(halted1), 1);
    chk({tag, ".phase"}, int'({clk1, clkd1, clke1, clks1}), 0);
    chk({tag, ".step_out"}, int'(so1), 0);
    chk({tag, ".step_idx"}, int'(idx1), 0);
    chk({tag, ".wrap"}, int'(wrap1), 0);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       clr;
    logic [3:0] ph;
    logic [5:0] so;
    logic [2:0] idx;
    logic       wr;
    logic       hl;
  } vec_t;

  vec_t       tbl[56];
  logic [3:0] pat[4];

  task automatic run_instr(input logic with_clr, input int exp_wraps, input string tag);
    int   rises, wraps, done_at;
    logic prev;
    mode1 = M_INST; go1 = 1'b1; clr1 = with_clr;
    cyc();
    go1 = 1'b0; clr1 = 1'b0;
    chk({tag, ".started"}, int'(halted1), 0);
    rises = 0; wraps = 0; done_at = -1; prev = clk1;
    for (int j = 1; j <= 30; j++) begin
      cyc();
      if (clk1 && !prev) rises++;
      prev = clk1;
      if (wrap1) wraps++;
      if (j == 1) begin
        chk({tag, ".first_step"}, int'(so1), 6'b000001);
        chk({tag, ".first_wrap"}, int'(wrap1), exp_wraps);
      end
      if (halted1 && (done_at < 0)) done_at = j;
    end
    chk({tag, ".clk_cycles"}, rises, 6);
    chk({tag, ".wraps"}, wraps, exp_wraps);
    chk({tag, ".halt_clk"}, done_at, 24);
    chk({tag, ".end_step"}, int'(so1), 6'b100000);
    chk({tag, ".halted"}, int'(halted1), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected to finish");
    $fatal(1);
  end

  initial begin
    int   hi_cnt;
    int   found;
    mode1 = M_HALT; mode2 = M_HALT;
    go1 = 1'b0; go2 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;

    // power-on reset, then 20 CLKs parked in HALT (a go in HALT must be ignored)
    #2 reset_n = 1'b0;
    #1 check_por("reset_async");
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      go1 = (i == 5);
      cyc();
      check_por($sformatf("por[%0d]", i));
    end
    go1 = 1'b0;

    // RUN at DIV=1 with ignored step_clr, then HALT requested at q=1 and a clear
    pat[0] = 4'b1010; pat[1] = 4'b1111; pat[2] = 4'b0110; pat[3] = 4'b0000;
    tbl[0] = '{mode: M_RUN, clr: 1'b0, ph: 4'b0000, so: 6'd0, idx: 3'd0, wr: 1'b0, hl: 1'b0};
    for (int k = 1; k <= 50; k++) begin
      int p, s;
      p = (k - 1) % 4;
      s = ((k - 1) / 4) % 6;
      tbl[k].mode = M_RUN;
      tbl[k].clr  = ((k % 7) == 3);
      tbl[k].ph   = pat[p];
      tbl[k].so   = 6'(1 << s);
      tbl[k].idx  = 3'(s);
      tbl[k].wr   = (p == 0) && (k > 1) && (s == 0);
      tbl[k].hl   = 1'b0;
    end
    tbl[51] = '{mode: M_HALT, clr: 1'b0, ph: 4'b0110, so: 6'b000001, idx: 3'd0, wr: 1'b0, hl: 1'b0};
    tbl[52] = '{mode: M_HALT, clr: 1'b0, ph: 4'b0000, so: 6'b000001, idx: 3'd0, wr: 1'b0, hl: 1'b1};
    tbl[53] = '{mode: M_HALT, clr: 1'b0, ph: 4'b0000, so: 6'b000001, idx: 3'd0, wr: 1'b0, hl: 1'b1};
    tbl[54] = '{mode: M_HALT, clr: 1'b1, ph: 4'b0000, so: 6'b000000, idx: 3'd0, wr: 1'b0, hl: 1'b1};
    tbl[55] = '{mode: M_HALT, clr: 1'b0, ph: 4'b0000, so: 6'b000000, idx: 3'd0, wr: 1'b0, hl: 1'b1};

    for (int i = 0; i < 56; i++) begin
      mode1 = tbl[i].mode;
      clr1  = tbl[i].clr;
      cyc();
      chk($sformatf("run[%0d].phase", i), int'({clk1, clkd1, clke1, clks1}), int'(tbl[i].ph));
      chk($sformatf("run[%0d].step_out", i), int'(so1), int'(tbl[i].so));
      chk($sformatf("run[%0d].step_idx", i), int'(idx1), int'(tbl[i].idx));
      chk($sformatf("run[%0d].wrap", i), int'(wrap1), int'(tbl[i].wr));
      chk($sformatf("run[%0d].halted", i), int'(halted1), int'(tbl[i].hl));
    end
    clr1 = 1'b0;

    // single instruction: from unprimed, from last step (wraps), and with a simultaneous clear
    run_instr(1'b0, 0, "instr_unprimed");
    run_instr(1'b0, 1, "instr_next");
    run_instr(1'b1, 0, "instr_clr_go");

    // single cycle at DIV=2 with a second go mid-cycle
    mode2 = M_CYC; go2 = 1'b1;
    cyc();
    go2 = 1'b0;
    chk("cyc[0].clk", int'(clk2), 0);
    chk("cyc[0].halted", int'(halted2), 0);
    hi_cnt = 0;
    for (int j = 1; j <= 12; j++) begin
      go2 = (j == 4);
      cyc();
      if (clk2) hi_cnt++;
      chk($sformatf("cyc[%0d].clk", j), int'(clk2), int'((j >= 2) && (j <= 5)));
      chk($sformatf("cyc[%0d].halted", j), int'(halted2), int'(j >= 8));
    end
    go2 = 1'b0;
    chk("cyc.clk_high_count", hi_cnt, 4);
    chk("cyc.step_out", int'(so2), 6'b000001);

    // reset asserted at q=1 during RUN must drop the phases without a CLK edge
    mode1 = M_RUN;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (clks1) begin
        found = 1;
        break;
      end
    end
    chk("rst_mid.reached_q1", found, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid.clk", int'(clk1), 0);
    chk("rst_mid.clks", int'(clks1), 0);
    chk("rst_mid.halted", int'(halted1), 1);
    chk("rst_mid.step_out", int'(so1), 0);
    mode1 = M_HALT;
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_por($sformatf("post_rst[%0d]", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
